adc_16_to_udp_32bit: RTL and testbench



---
 rtl/adc_udp_pkg.sv | 26 ++
 rtl/adc_16_to_udp_32bit_fifo.sv | 78 +++++++
 rtl/adc_16_to_udp_32bit.sv | 145 ++++++++++++++
 tb/tb_adc_16_to_udp_32bit.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_udp_pkg.sv
`default_nettype none
//============================================================================
// Module      : adc_udp_pkg
// Description : Shared types and helpers for the ADC-to-UDP sample packer:
//               transmit FSM state encoding and payload byte-count helper.
// Revision    : 1.0  initial release
//============================================================================
package adc_udp_pkg;

    // Transmit sequencing states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int c_bytes_per_word = 4;

    // Payload length in bytes for a packet of the given number of 32-bit words
    function automatic logic [15:0] byte_count(input logic [15:0] words);
        return 16'(32'(words) * c_bytes_per_word);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_16_to_udp_32bit_fifo.sv
`default_nettype none
//============================================================================
// Module      : sync_fifo_32
// Description : Single-clock 32-bit word FIFO with registered read data.
//               Writes are refused when full and reads when empty; a read in
//               the same cycle never makes room for a write to a full FIFO.
// Revision    : 1.0  initial release
//============================================================================
module sync_fifo_32 #(
    parameter int FIFO_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [31:0]       wr_data,
    input  logic              pop,
    output logic [31:0]       rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_rd_data;
    logic              w_wr_en;
    logic              w_rd_en;

    assign full    = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_rd_data;

    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;

    // Storage array; left unreset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered read port: data appears the cycle after the pop and holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_16_to_udp_32bit.sv
`default_nettype none
//============================================================================
// Module      : adc_16_to_udp_32bit
// Description : Packs pairs of 16-bit ADC samples into 32-bit words (first
//               sample in the upper half), buffers them, and feeds the UDP
//               transmitter one full packet at a time on its word requests.
// Revision    : 1.0  initial release
//============================================================================
module adc_16_to_udp_32bit #(
    parameter logic [15:0] PKT_WORDS  = 16'd256,
    parameter int          FIFO_DEPTH = 1024,
    parameter int          ADDR_W     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [31:0] tx_data,
    output logic        overflow
);
    import adc_udp_pkg::*;

    localparam logic [ADDR_W:0] c_pkt_words = (ADDR_W+1)'(PKT_WORDS);
    localparam logic [15:0]     c_byte_num  = byte_count(PKT_WORDS);

    logic              r_half;
    logic [15:0]       r_hold;
    logic              r_overflow;
    logic [ADDR_W:0]   r_sent;
    tx_state_t         r_state;
    tx_state_t         w_next_state;
    logic              w_push;
    logic [31:0]       w_word;
    logic              w_pop;
    logic              w_start;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W:0]   w_count;
    logic [31:0]       w_rd_data;

    // The second sample of a pair completes a word; it is pushed that same cycle
    assign w_push = adc_valid && r_half;
    assign w_word = {r_hold, adc_data};

    assign tx_start_en = w_start;
    assign tx_byte_num = c_byte_num;
    assign tx_data     = w_rd_data;
    assign overflow    = r_overflow;

    sync_fifo_32 #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (w_word),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Sample pairing: phase advances on every valid sample, even if its word is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half <= 1'b0;
            r_hold <= '0;
        end else if (adc_valid) begin
            r_half <= ~r_half;
            if (!r_half) begin
                r_hold <= adc_data;
            end
        end
    end

    // Flag a word lost to a full FIFO on the cycle after the attempted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Words handed out in the current packet; cleared as each packet starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sent <= '0;
        end else if (r_state == START) begin
            r_sent <= '0;
        end else if (w_pop) begin
            r_sent <= r_sent + (ADDR_W+1)'(1);
        end
    end

    // Next-state and FSM outputs; requests and done pulses outside their state are ignored
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_count >= c_pkt_words) begin
                    w_next_state = START;
                end
            end
            START: begin
                w_start      = 1'b1;
                w_next_state = SEND;
            end
            SEND: begin
                if (r_sent == c_pkt_words) begin
                    w_next_state = WAIT_DONE;
                end else if (tx_req && !w_empty) begin
                    w_pop = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_16_to_udp_32bit.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_adc_16_to_udp_32bit
// Description : Self-checking bench for adc_16_to_udp_32bit. Four instances
//               with different packet/FIFO sizes share the input stimulus;
//               each scenario focuses on one instance.
// Revision    : 1.0  initial release
//============================================================================
module tb_adc_16_to_udp_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        tx_req;
    logic        tx_done;

    logic [3:0]        start_en;
    logic [3:0]        ovf;
    logic [3:0][31:0]  data;
    logic [3:0][15:0]  bnum;

    int errors = 0;
    int checks = 0;
    int pkt_of [4] = '{256, 2, 4, 8};

    always #5 clk = ~clk;

    adc_16_to_udp_32bit u_dut0 (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(start_en[0]),
        .tx_byte_num(bnum[0]), .tx_data(data[0]), .overflow(ovf[0])
    );

    adc_16_to_udp_32bit #(.PKT_WORDS(16'd2), .FIFO_DEPTH(16), .ADDR_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(start_en[1]),
        .tx_byte_num(bnum[1]), .tx_data(data[1]), .overflow(ovf[1])
    );

    adc_16_to_udp_32bit #(.PKT_WORDS(16'd4), .FIFO_DEPTH(16), .ADDR_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(start_en[2]),
        .tx_byte_num(bnum[2]), .tx_data(data[2]), .overflow(ovf[2])
    );

    adc_16_to_udp_32bit #(.PKT_WORDS(16'd8), .FIFO_DEPTH(8), .ADDR_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(start_en[3]),
        .tx_byte_num(bnum[3]), .tx_data(data[3]), .overflow(ovf[3])
    );

    // Inputs change at the falling edge; outputs are read there too.
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst_n     = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        tx_req    = 1'b0;
        tx_done   = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic wait_start(input int inst, input int budget, output bit found);
        found = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick;
            if (start_en[inst] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            adc_data  = 16'($urandom);
            adc_valid = 1'($urandom_range(0, 1));
            tx_req    = 1'($urandom_range(0, 1));
            tx_done   = 1'($urandom_range(0, 1));
            tick;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (start_en[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_start inst%0d cyc%0d: got %b expected 0", i, c, start_en[i]);
                end
                checks++;
                if (data[i] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_data inst%0d cyc%0d: got %h expected 0", i, c, data[i]);
                end
                checks++;
                if (ovf[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_overflow inst%0d cyc%0d: got %b expected 0", i, c, ovf[i]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bnum[i] !== 16'(pkt_of[i] * 4)) begin
                errors++;
                $display("FAIL byte_num inst%0d: got %0d expected %0d", i, bnum[i], pkt_of[i] * 4);
            end
        end
        adc_valid = 1'b0;
        tx_req    = 1'b0;
        tx_done   = 1'b0;
        rst_n     = 1'b1;
        tick;
    endtask

    task automatic test_packing;
        logic [15:0] s [4];
        logic [31:0] w [2];
        int starts;
        s[0] = 16'h1111; s[1] = 16'h2222; s[2] = 16'h3333; s[3] = 16'h4444;
        for (int k = 0; k < 2; k++) w[k] = {s[2*k], s[2*k+1]};
        apply_reset;
        starts = 0;
        for (int k = 0; k < 4; k++) begin
            adc_valid = 1'b1;
            adc_data  = s[k];
            tick;
            if (start_en[1] === 1'b1) starts++;
        end
        adc_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (start_en[1] === 1'b1) starts++;
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL pack_start_count: got %0d pulses expected 1", starts);
        end
        checks++;
        if (data[1] !== 32'h0) begin
            errors++;
            $display("FAIL pack_data_before_req: got %h expected 0", data[1]);
        end
        tx_req = 1'b1; tick; tx_req = 1'b0;
        checks++;
        if (data[1] !== w[0]) begin
            errors++;
            $display("FAIL pack_word0: got %h expected %h", data[1], w[0]);
        end
        tick;
        checks++;
        if (data[1] !== w[0]) begin
            errors++;
            $display("FAIL pack_hold_no_req: got %h expected %h", data[1], w[0]);
        end
        tx_req = 1'b1; tick; tx_req = 1'b0;
        checks++;
        if (data[1] !== w[1]) begin
            errors++;
            $display("FAIL pack_word1: got %h expected %h", data[1], w[1]);
        end
        tick;
        tx_done = 1'b1; tick; tx_done = 1'b0;
        tick;
    endtask

    task automatic test_threshold;
        int starts;
        apply_reset;
        starts = 0;
        for (int k = 0; k < 7; k++) begin
            adc_valid = 1'b1;
            adc_data  = 16'($urandom);
            tick;
            if (start_en[2] === 1'b1) starts++;
        end
        adc_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (start_en[2] === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL thresh_early_start: got %0d pulses expected 0", starts);
        end
        adc_valid = 1'b1;
        adc_data  = 16'($urandom);
        tick;
        adc_valid = 1'b0;
        checks++;
        if (start_en[2] !== 1'b0) begin
            errors++;
            $display("FAIL thresh_cycle1: got %b expected 0", start_en[2]);
        end
        tick;
        checks++;
        if (start_en[2] !== 1'b1) begin
            errors++;
            $display("FAIL thresh_cycle2: got %b expected 1", start_en[2]);
        end
        tick;
        checks++;
        if (start_en[2] !== 1'b0) begin
            errors++;
            $display("FAIL thresh_cycle3: got %b expected 0", start_en[2]);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] samp;
        logic [15:0] hold;
        bit          mhalf;
        logic [31:0] q [$];
        logic [31:0] last;
        int phase;
        int nreq;
        int pkts;
        apply_reset;
        samp = 16'h0; hold = 16'h0; mhalf = 1'b0; last = 32'h0;
        phase = 0; nreq = 0; pkts = 0;
        for (int c = 0; c < 400 && pkts < 3; c++) begin
            adc_valid = 1'b1;
            adc_data  = samp;
            if (mhalf) q.push_back({hold, samp});
            else       hold = samp;
            mhalf   = !mhalf;
            samp    = samp + 16'h1;
            tx_req  = (phase == 2);
            tx_done = (phase == 3);
            tick;
            checks++;
            if (ovf[2] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_overflow cyc%0d: got %b expected 0", c, ovf[2]);
            end
            if (phase == 0) begin
                if (start_en[2] === 1'b1) phase = 1;
            end else begin
                checks++;
                if (start_en[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_extra_start cyc%0d: got %b expected 0", c, start_en[2]);
                end
                if (phase == 1) begin
                    phase = 2;
                end else if (phase == 2) begin
                    nreq++;
                    if (nreq <= 4) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_no_word cyc%0d: got %h expected none pending", c, data[2]);
                        end else begin
                            last = q.pop_front();
                            if (data[2] !== last) begin
                                errors++;
                                $display("FAIL b2b_word pkt%0d req%0d: got %h expected %h", pkts, nreq, data[2], last);
                            end
                        end
                    end else begin
                        checks++;
                        if (data[2] !== last) begin
                            errors++;
                            $display("FAIL b2b_extra_req_hold pkt%0d: got %h expected %h", pkts, data[2], last);
                        end
                        phase = 3;
                        nreq  = 0;
                    end
                end else begin
                    phase = 0;
                    pkts++;
                end
            end
        end
        adc_valid = 1'b0;
        tx_req    = 1'b0;
        tx_done   = 1'b0;
        checks++;
        if (pkts != 3) begin
            errors++;
            $display("FAIL b2b_packets: got %0d expected 3", pkts);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] hold;
        bit          mhalf;
        bit          drop;
        int          mcount;
        int          npulse;
        int          starts;
        logic [31:0] q [$];
        logic [31:0] exp_w;
        apply_reset;
        hold = 16'h0; mhalf = 1'b0; mcount = 0; npulse = 0;
        for (int it = 0; it < 24; it++) begin
            drop = 1'b0;
            if (it < 20) begin
                adc_valid = 1'b1;
                adc_data  = 16'($urandom);
                if (mhalf) begin
                    if (mcount < 8) begin
                        q.push_back({hold, adc_data});
                        mcount++;
                    end else begin
                        drop = 1'b1;
                    end
                end else begin
                    hold = adc_data;
                end
                mhalf = !mhalf;
            end else begin
                adc_valid = 1'b0;
            end
            tick;
            checks++;
            if (ovf[3] !== drop) begin
                errors++;
                $display("FAIL ovf_pulse it%0d: got %b expected %b", it, ovf[3], drop);
            end
            if (ovf[3] === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 2) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected 2", npulse);
        end
        for (int r = 0; r < 9; r++) begin
            tx_req = 1'b1;
            tick;
            exp_w = (r < 8) ? q[r] : q[7];
            checks++;
            if (data[3] !== exp_w) begin
                errors++;
                $display("FAIL ovf_deliver req%0d: got %h expected %h", r, data[3], exp_w);
            end
        end
        tx_req = 1'b0;
        tick;
        tx_done = 1'b1; tick; tx_done = 1'b0;
        starts = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (start_en[3] === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL ovf_no_second_packet: got %0d pulses expected 0", starts);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] a [8];
        logic [15:0] b [8];
        logic [31:0] exp_w;
        bit found;
        int starts;
        apply_reset;
        for (int k = 0; k < 8; k++) begin
            a[k]      = 16'($urandom);
            adc_valid = 1'b1;
            adc_data  = a[k];
            tick;
        end
        adc_valid = 1'b0;
        wait_start(2, 10, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_first_start: got none expected pulse within 10 cycles");
        end
        tick;
        for (int k = 0; k < 2; k++) begin
            tx_req = 1'b1;
            tick;
            exp_w = {a[2*k], a[2*k+1]};
            checks++;
            if (data[2] !== exp_w) begin
                errors++;
                $display("FAIL mid_first_word%0d: got %h expected %h", k, data[2], exp_w);
            end
        end
        tx_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        checks++;
        if (data[2] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_data: got %h expected 0", data[2]);
        end
        checks++;
        if (start_en[2] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_start: got %b expected 0", start_en[2]);
        end
        tick;
        rst_n = 1'b1;
        tick;
        starts = 0;
        for (int k = 0; k < 8; k++) begin
            b[k]      = 16'($urandom);
            adc_valid = 1'b1;
            adc_data  = b[k];
            tick;
            if (start_en[2] === 1'b1) starts++;
        end
        adc_valid = 1'b0;
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL mid_stale_start: got %0d pulses expected 0", starts);
        end
        wait_start(2, 10, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_second_start: got none expected pulse within 10 cycles");
        end
        tick;
        for (int k = 0; k < 4; k++) begin
            tx_req = 1'b1;
            tick;
            exp_w = {b[2*k], b[2*k+1]};
            checks++;
            if (data[2] !== exp_w) begin
                errors++;
                $display("FAIL mid_new_word%0d: got %h expected %h", k, data[2], exp_w);
            end
        end
        tx_req = 1'b0;
        tick;
        tx_done = 1'b1; tick; tx_done = 1'b0;
        tick;
    endtask

    initial begin
        rst_n     = 1'b0;
        adc_data  = '0;
        adc_valid = 1'b0;
        tx_req    = 1'b0;
        tx_done   = 1'b0;
        test_reset;
        test_packing;
        test_threshold;
        test_back_to_back;
        test_overflow;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
